// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter: shares one combinational ALU between two valid/ready requesters.
// Optional macro ALU_ARB_RR_EN selects round-robin arbitration. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_arbiter #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [3:0]    req_op0,
  input  logic [3:0]    req_op1,
  input  logic [DW-1:0] req_a0,
  input  logic [DW-1:0] req_b0,
  input  logic [DW-1:0] req_a1,
  input  logic [DW-1:0] req_b1,
  output logic [1:0]    rsp_valid,
  input  logic [1:0]    rsp_ready,
  output logic [DW-1:0] rsp_data0,
  output logic [DW-1:0] rsp_data1,
  output logic [1:0]    rsp_zero,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_op,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_zero
);

  localparam logic [3:0] c_op_idle = 4'hF;

  logic          iss_v;
  logic          iss_id;
  logic [1:0]    w_elig;
  logic [1:0]    w_grant;
  logic [1:0]    r_rsp_v;
  logic [1:0]    r_rsp_zero;
  logic [DW-1:0] r_rsp_data [2];

  // A requester may reissue as soon as its slot is free or being drained now.
  assign w_elig[0] = req_valid[0] & ~(iss_v & ~iss_id) & (~r_rsp_v[0] | rsp_ready[0]);
  assign w_elig[1] = req_valid[1] & ~(iss_v &  iss_id) & (~r_rsp_v[1] | rsp_ready[1]);

`ifdef ALU_ARB_RR_EN
  logic r_last;

  assign w_grant[0] = w_elig[0] & (~w_elig[1] |  r_last);
  assign w_grant[1] = w_elig[1] & (~w_elig[0] | ~r_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (|w_grant) begin
      r_last <= w_grant[1];
    end
  end
`else
  assign w_grant[0] = w_elig[0];
  assign w_grant[1] = w_elig[1] & ~w_elig[0];
`endif

  assign req_ready = rst_n ? w_grant : 2'b00;

  // Idle cycles force the null opcode so the ALU output reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= c_op_idle;
      iss_v  <= 1'b0;
      iss_id <= 1'b0;
    end else if (w_grant[0]) begin
      alu_a  <= req_a0;
      alu_b  <= req_b0;
      alu_op <= req_op0;
      iss_v  <= 1'b1;
      iss_id <= 1'b0;
    end else if (w_grant[1]) begin
      alu_a  <= req_a1;
      alu_b  <= req_b1;
      alu_op <= req_op1;
      iss_v  <= 1'b1;
      iss_id <= 1'b1;
    end else begin
      alu_op <= c_op_idle;
      iss_v  <= 1'b0;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_slot
    logic w_cap;
    assign w_cap = iss_v & (iss_id == 1'(g));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rsp_v[g]    <= 1'b0;
        r_rsp_zero[g] <= 1'b0;
        r_rsp_data[g] <= '0;
      end else if (w_cap) begin
        r_rsp_v[g]    <= 1'b1;
        r_rsp_zero[g] <= alu_zero;
        r_rsp_data[g] <= alu_out;
      end else if (rsp_ready[g]) begin
        r_rsp_v[g]    <= 1'b0;
      end
    end
  end

  assign rsp_valid = r_rsp_v;
  assign rsp_zero  = r_rsp_zero;
  assign rsp_data0 = r_rsp_data[0];
  assign rsp_data1 = r_rsp_data[1];

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu_arbiter: directed self-checking bench for alu_arbiter. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_alu_arbiter;

  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [3:0]    req_op0, req_op1;
  logic [DW-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [DW-1:0] rsp_data0, rsp_data1;
  logic [1:0]    rsp_zero;
  logic [DW-1:0] alu_a, alu_b;
  logic [3:0]    alu_op;
  logic [DW-1:0] alu_out;
  logic          alu_zero;

  int tests = 0;
  int fails = 0;

  alu_arbiter #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data0(rsp_data0), .rsp_data1(rsp_data1), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero)
  );

  // Reference ALU attached to the arbiter's registered operand outputs.
  always_comb begin
    alu_out = '0;
    case (alu_op)
      4'd0: alu_out = alu_a & alu_b;
      4'd1: alu_out = alu_a | alu_b;
      4'd2: alu_out = alu_a ^ alu_b;
      4'd3: alu_out = alu_a << alu_b[4:0];
      4'd4: alu_out = alu_a >> alu_b[4:0];
      4'd5: alu_out = alu_a + alu_b;
      4'd6: alu_out = alu_a - alu_b;
      default: alu_out = '0;
    endcase
    alu_zero = (alu_out == '0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 2'b00;
    req_op0 = 4'd0; req_op1 = 4'd0;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_alu_op", 32'(alu_op), 32'hF);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_b", alu_b, 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data0", rsp_data0, 32'h0);
    chk("rst_rsp_zero", 32'(rsp_zero), 32'h0);
    req_valid = 2'b00;
    rst_n = 1'b1;
    tick();

    // Single ADD from requester 0
    req_valid = 2'b01; req_op0 = 4'd5; req_a0 = 32'd3; req_b0 = 32'd4;
    #1 chk("add_ready", 32'(req_ready), 32'h1);
    tick(); req_valid = 2'b00;
    #1 chk("add_issue_op", 32'(alu_op), 32'h5);
    chk("add_issue_a", alu_a, 32'd3);
    chk("add_n1_rsp_valid", 32'(rsp_valid), 32'h0);
    tick();
    chk("add_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("add_data", rsp_data0, 32'd7);
    chk("add_zero", 32'(rsp_zero), 32'h0);
    chk("add_idle_op", 32'(alu_op), 32'hF);

    // Backpressure on requester 0
    req_valid = 2'b01; req_a0 = 32'd10; req_b0 = 32'd20;
    #1 chk("bp_ready", 32'(req_ready), 32'h0);
    tick();
    chk("bp_ready_hold", 32'(req_ready), 32'h0);
    chk("bp_data_hold", rsp_data0, 32'd7);
    chk("bp_valid_hold", 32'(rsp_valid), 32'h1);
    rsp_ready = 2'b01;
    #1 chk("bp_release_ready", 32'(req_ready), 32'h1);
    tick(); req_valid = 2'b00; rsp_ready = 2'b00;
    #1 chk("bp_slot_cleared", 32'(rsp_valid), 32'h0);
    chk("bp_issue_a", alu_a, 32'd10);
    tick();
    chk("bp_new_valid", 32'(rsp_valid), 32'h1);
    chk("bp_new_data", rsp_data0, 32'd30);
    rsp_ready = 2'b01;
    tick(); rsp_ready = 2'b00;
    #1 chk("bp_drained", 32'(rsp_valid), 32'h0);

    // SUB to zero, then unused opcode, from requester 1
    req_valid = 2'b10; req_op1 = 4'd6; req_a1 = 32'h1234; req_b1 = 32'h1234;
    #1 chk("sub_ready", 32'(req_ready), 32'h2);
    tick(); req_valid = 2'b00;
    tick();
    chk("sub_valid", 32'(rsp_valid), 32'h2);
    chk("sub_data", rsp_data1, 32'h0);
    chk("sub_zero", 32'(rsp_zero), 32'h2);
    rsp_ready = 2'b10; req_valid = 2'b10; req_op1 = 4'd9; req_a1 = 32'd5; req_b1 = 32'd5;
    #1 chk("op9_ready", 32'(req_ready), 32'h2);
    tick(); req_valid = 2'b00; rsp_ready = 2'b00;
    #1 chk("op9_passthru", 32'(alu_op), 32'h9);
    chk("op9_slot_cleared", 32'(rsp_valid), 32'h0);
    tick();
    chk("op9_valid", 32'(rsp_valid), 32'h2);
    chk("op9_data", rsp_data1, 32'h0);
    chk("op9_zero", 32'(rsp_zero), 32'h2);
    rsp_ready = 2'b10;
    tick(); rsp_ready = 2'b00;

    // Overlap: SLL from 0 then XOR from 1 on consecutive cycles
    req_valid = 2'b01; req_op0 = 4'd3; req_a0 = 32'd1; req_b0 = 32'd4;
    #1 chk("ovl_ready0", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b10; req_op1 = 4'd2; req_a1 = 32'hF0; req_b1 = 32'hFF;
    #1 chk("ovl_ready1", 32'(req_ready), 32'h2);
    tick(); req_valid = 2'b00;
    #1 chk("ovl_valid0", 32'(rsp_valid), 32'h1);
    chk("ovl_data0", rsp_data0, 32'd16);
    tick();
    chk("ovl_valid_both", 32'(rsp_valid), 32'h3);
    chk("ovl_data1", rsp_data1, 32'h0F);
    chk("ovl_data0_hold", rsp_data0, 32'd16);
    rsp_ready = 2'b11;
    tick();
    chk("ovl_drained", 32'(rsp_valid), 32'h0);

    // Contention with both requesters streaming
    req_op0 = 4'd5; req_a0 = 32'd1; req_b0 = 32'd1;
    req_op1 = 4'd1; req_a1 = 32'd2; req_b1 = 32'd4;
    req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("cont_grant_%0d", k), 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      tick();
    end
    req_valid = 2'b00;
    #1 chk("cont_data1", rsp_data1, 32'd6);
    tick();
    chk("cont_data0", rsp_data0, 32'd2);
    // Both eligible again after requester 0 was the last winner
    req_valid = 2'b11;
`ifdef ALU_ARB_RR_EN
    #1 chk("prio_after_0", 32'(req_ready), 32'h2);
`else
    #1 chk("prio_after_0", 32'(req_ready), 32'h1);
`endif
    tick(); req_valid = 2'b00;
    tick(); tick();
    rsp_ready = 2'b00;
    #1 chk("cont_drained", 32'(rsp_valid), 32'h0);

    // Reset while an operation is in flight
    req_valid = 2'b01; req_op0 = 4'd5; req_a0 = 32'd7; req_b0 = 32'd8;
    #1 chk("mid_ready", 32'(req_ready), 32'h1);
    tick(); req_valid = 2'b00;
    #1 chk("mid_issued", alu_a, 32'd7);
    rst_n = 1'b0;
    #1 chk("mid_alu_op", 32'(alu_op), 32'hF);
    chk("mid_alu_a", alu_a, 32'h0);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'h0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("mid_no_rsp", 32'(rsp_valid), 32'h0);
    chk("mid_data0", rsp_data0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer that shares the single combinational integer ALU between two requesters, for example the integer pipeline and a debug/CSR path. It accepts operation requests with valid/ready handshakes, registers the granted operands onto the ALU inputs, and captures the ALU result and zero flag into a one-entry response buffer per requester. Throughput is one operation per cycle overall. Each requester may have at most one operation outstanding.

## Interface
Parameters:
- `DW`, default 32: operand and result width; must match the ALU width.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid[1:0]`  in  2  request valid, one bit per requester.
- `req_ready[1:0]`  out  2  request accepted this cycle; combinational.
- `req_op0`, `req_op1`  in  4 each  ALU opcode: 0 AND, 1 OR, 2 XOR, 3 SLL, 4 SRL, 5 ADD, 6 SUB, 7–15 give result 0.
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  in  DW each  operands.
- `rsp_valid[1:0]`  out  2  response slot full.
- `rsp_ready[1:0]`  in  2  requester consumes the response.
- `rsp_data0`, `rsp_data1`  out  DW each  captured ALU result.
- `rsp_zero[1:0]`  out  2  captured ALU zero flag.
- `alu_a`, `alu_b`  out  DW  registered ALU operands.
- `alu_op`  out  4  registered ALU opcode.
- `alu_out`  in  DW  ALU result, combinational from the `alu_*` outputs.
- `alu_zero`  in  1  ALU zero flag.

## Operation
- **Pipeline:**
  - Stage I (issue) holds `alu_a`, `alu_b`, `alu_op`, plus `iss_v` (valid) and `iss_id` (requester id).
  - Stage R (response) holds one slot per requester.
- **Eligibility:** requester i is eligible when `req_valid[i]`=1, no op for i is in stage I, and either `rsp_valid[i]`=0 or `rsp_ready[i]`=1 this cycle.
- **Grant:** at most one eligible requester per cycle; `req_ready[i]`=1 only for the winner. A request is accepted when `req_valid[i]` && `req_ready[i]`.
- **On accept:** load the operands and opcode into stage I, set `iss_v`=1 and `iss_id`=i.
- **No accept:**
  - `iss_v` clears to 0.
  - `alu_op` is forced to 4'hF so the ALU drives 0.
  - `alu_a` and `alu_b` hold their values.
- **Capture:** when `iss_v`=1, capture `alu_out`/`alu_zero` into slot `iss_id` and set `rsp_valid[iss_id]`.
- **Release:** `rsp_valid[i]` clears on `rsp_valid[i]` && `rsp_ready[i]`, unless a new capture for i occurs in the same cycle; in that case it stays 1 with the new data.
- **Opcodes:** passed through unmodified. An opcode of 7–15 returns data 0 with zero=1.
- **Arithmetic:** ADD/SUB wrap modulo 2^DW. Shift semantics are the ALU's; the block does not check them.
- **Stability:** while stalled, a requester must hold `req_valid` and its operands stable until accepted. The block does not check this.

## Timing
- Accept in cycle N → `alu_*` valid in N+1 → `rsp_valid` high from N+2.
- Back-to-back: requesters alternating every cycle sustain one op per cycle.
- Same requester: at most one op every 2 cycles, provided the response is consumed immediately.
- **Reset values:**
  - `alu_a`, `alu_b` = 0; `alu_op` = 4'hF; `iss_v` = 0.
  - `rsp_valid` = 2'b00; `rsp_data*` = 0; `rsp_zero` = 2'b00.
  - Priority pointer favours requester 0.
  - `req_ready` = 00 while reset is asserted.
- **Reset mid-operation:** in-flight and buffered results are discarded with no response. Outputs take reset values immediately, asynchronously.
- **Simultaneous request from both, fixed priority (default):** requester 0 wins every time.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit pointer names the last winner.
  - When both requesters are eligible, the other one wins.
  - The pointer updates only on an accept and resets to "last = 1", so requester 0 wins first.
- Not defined: fixed priority, requester 0 over requester 1. No pointer flop is built.

## Test plan
- **Single ADD:** reset, then requester 0 sends op=5, a=3, b=4 → `req_ready[0]`=1 in cycle N; `rsp_valid[0]`=1 at N+2 with data=7, zero=0.
- **SUB to zero:** requester 1 sends op=6, a=b=32'h1234 → data 0, `rsp_zero[1]`=1. Then op=9, a=5, b=5 → data 0, zero=1.
- **Contention:** both requesters valid continuously with `rsp_ready`=11.
  - Fixed build: requester 0 is granted at N, N+2, …, and requester 1 is granted at N+1, N+3, … only while requester 0 is ineligible.
  - `ALU_ARB_RR_EN` build: grants alternate 0,1,0,1.
- **Backpressure:** `rsp_ready[0]`=0 with `rsp_valid[0]`=1 → `req_ready[0]` stays 0 and data holds. Raising `rsp_ready[0]` gives same-cycle acceptance of the next request.
- **Overlap:** op SLL a=1, b=4 from requester 0 and op XOR a=F0, b=FF from requester 1 on consecutive cycles → responses 16 and 0F, each returned to its own requester.
- **Reset mid-flight:** accept a request, assert `rst_n`=0 in N+1 → no `rsp_valid`, and all outputs at their reset values.
